// File: rtl/my_alu_pkg.sv
// Shared opcode definitions for the my_alu datapath.
package my_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

endpackage

// File: rtl/my_alu_core.sv
// Combinational ALU datapath producing next result and carry/borrow/shift-out flag.
// Latency: 0 (pure logic). No backpressure. Shifter present only when MY_ALU_SHIFT_EN is defined.
module my_alu_core
  import my_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] c_nxt,
  output logic             co_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra MSB of the zero-extended difference is the borrow (set iff a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    c_nxt  = '0;
    co_nxt = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        c_nxt  = sum[WIDTH-1:0];
        co_nxt = sum[WIDTH];
      end
      OP_SUB: begin
        c_nxt  = diff[WIDTH-1:0];
        co_nxt = diff[WIDTH];
      end
      OP_AND: c_nxt = a & b;
      OP_OR:  c_nxt = a | b;
      OP_XOR: c_nxt = a ^ b;
      OP_NOT: c_nxt = ~a;
`ifdef MY_ALU_SHIFT_EN
      OP_SHL: begin
        c_nxt  = {a[WIDTH-2:0], 1'b0};
        co_nxt = a[WIDTH-1];
      end
      OP_SHR: begin
        c_nxt  = {1'b0, a[WIDTH-1:1]};
        co_nxt = a[0];
      end
`endif
      default: begin
        c_nxt  = '0;
        co_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/my_alu.sv
// Registered ALU: result and carry flag registered from my_alu_core (MY_ALU_SHIFT_EN enables SHL/SHR).
// Latency: 1 cycle, one op per cycle. No handshake/backpressure; async active-high reset clears outputs.
module my_alu
  import my_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] c,
  output logic             co
);

  logic [WIDTH-1:0] c_nxt;
  logic             co_nxt;

  my_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a     (a),
    .b     (b),
    .op    (op),
    .c_nxt (c_nxt),
    .co_nxt(co_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c  <= '0;
      co <= 1'b0;
    end else begin
      c  <= c_nxt;
      co <= co_nxt;
    end
  end

endmodule

// File: tb/tb_my_alu.sv
// Directed self-checking bench for my_alu with a queue scoreboard of expected {co,c}.
module tb_my_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic [3:0] c;
  logic       co;

  int checks = 0;
  int errors = 0;
  logic [4:0] sb[$];

  my_alu #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .op (op),
    .c  (c),
    .co (co)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one operation and record its expected outcome.
  task automatic drive(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                       input logic [4:0] exp);
    op = o;
    a  = x;
    b  = y;
    sb.push_back(exp);
  endtask

  // Compare outputs directly against a constant (reset behaviour).
  task automatic check_out(input string tag, input logic [4:0] exp);
    checks++;
    assert ({co, c} === exp) else begin
      errors++;
      $error("FAIL %s: observed co,c=%b expected %b", tag, {co, c}, exp);
    end
  endtask

  // Advance one edge, then pop the oldest expectation and compare.
  task automatic tick_check(input string tag);
    logic [4:0] exp;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, observed co,c=%b", tag, {co, c});
    end else begin
      exp = sb.pop_front();
      assert ({co, c} === exp) else begin
        errors++;
        $error("FAIL %s: observed co,c=%b expected %b", tag, {co, c}, exp);
      end
    end
  endtask

  logic [4:0] exp_shl;
  logic [4:0] exp_shr;
  logic [2:0] bb_op [5];
  logic [3:0] bb_a  [5];
  logic [3:0] bb_b  [5];
  logic [4:0] bb_exp[5];

  initial begin
`ifdef MY_ALU_SHIFT_EN
    exp_shl = 5'b1_0110;
    exp_shr = 5'b1_0101;
`else
    exp_shl = 5'b0_0000;
    exp_shr = 5'b0_0000;
`endif
    bb_op[0] = 3'b000; bb_a[0] = 4'b1111; bb_b[0] = 4'b0001; bb_exp[0] = 5'b1_0000;
    bb_op[1] = 3'b001; bb_a[1] = 4'b0001; bb_b[1] = 4'b0010; bb_exp[1] = 5'b1_1111;
    bb_op[2] = 3'b100; bb_a[2] = 4'b1110; bb_b[2] = 4'b0100; bb_exp[2] = 5'b0_1010;
    bb_op[3] = 3'b101; bb_a[3] = 4'b1010; bb_b[3] = 4'b1111; bb_exp[3] = 5'b0_0101;
    bb_op[4] = 3'b110; bb_a[4] = 4'b1011; bb_b[4] = 4'b0000; bb_exp[4] = exp_shl;

    rst = 1'b1; op = 3'b000; a = 4'b0000; b = 4'b0000;
    #2;
    check_out("reset_initial", 5'b0_0000);
    @(negedge clk);
    rst = 1'b0;

    // Load a non-zero result, then check reset clears it without a clock edge.
    drive(3'b000, 4'b1110, 4'b0000, 5'b0_1110);
    tick_check("add_1110_0000");
    rst = 1'b1;
    #1;
    check_out("reset_async", 5'b0_0000);
    @(negedge clk);
    rst = 1'b0;

    drive(3'b000, 4'b1111, 4'b0001, 5'b1_0000); tick_check("add_carry");
    @(negedge clk);
    drive(3'b001, 4'b1110, 4'b1010, 5'b0_0100); tick_check("sub_no_borrow");
    @(negedge clk);
    drive(3'b001, 4'b0001, 4'b0010, 5'b1_1111); tick_check("sub_borrow");
    @(negedge clk);
    drive(3'b010, 4'b1010, 4'b0001, 5'b0_0000); tick_check("and");
    @(negedge clk);
    drive(3'b011, 4'b1110, 4'b1000, 5'b0_1110); tick_check("or");
    @(negedge clk);
    drive(3'b100, 4'b1110, 4'b0100, 5'b0_1010); tick_check("xor");
    @(negedge clk);
    drive(3'b101, 4'b1010, 4'b0110, 5'b0_0101); tick_check("not");
    @(negedge clk);
    drive(3'b110, 4'b1011, 4'b0000, exp_shl);   tick_check("shl");
    @(negedge clk);
    drive(3'b111, 4'b1011, 4'b0000, exp_shr);   tick_check("shr");

    // Back-to-back: a new op every cycle, each result exactly one edge later.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(bb_op[i], bb_a[i], bb_b[i], bb_exp[i]);
      tick_check($sformatf("b2b_%0d", i));
    end

    // Mid-stream reset: pending result is discarded.
    @(negedge clk);
    drive(3'b001, 4'b1110, 4'b1010, 5'b0_0100);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check_out("reset_mid_immediate", 5'b0_0000);
    @(posedge clk);
    #1;
    check_out("reset_mid_held", 5'b0_0000);
    rst = 1'b0;
    sb.push_back(5'b0_0100);
    tick_check("resume_after_reset");
    @(negedge clk);
    drive(3'b000, 4'b1111, 4'b0001, 5'b1_0000);
    tick_check("resume_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
